// File: rtl/soc_system_vga_data_pkg.sv
// Shared constants for the VGA data sequencer: register map, bit positions, FSM states.
package soc_system_vga_data_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned BUS_W  = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_DATA   = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_GAP    = 2'd3;

  localparam int unsigned STS_DRAINED_BIT  = 4;
  localparam int unsigned STS_OVERFLOW_BIT = 5;

  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_FLUSH_BIT  = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_GAP     = 2'd2
  } seq_state_e;

endpackage

// File: rtl/soc_system_vga_data_fifo.sv
// DEPTH x 8 byte FIFO with flush; push is refused whenever full at cycle start.
module soc_system_vga_data_fifo
  import soc_system_vga_data_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [CNT_W-1:0]  count,
  output logic              full_c,
  output logic              empty_c,
  output logic [DATA_W-1:0] head_c,
  output logic [DATA_W-1:0] next_head_c,
  output logic              push_acc_c,
  output logic              pop_acc_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_nxt_c, rd_nxt_c;
  logic [CNT_W-1:0]  count_q, count_d;

  // Power-of-two DEPTH lets the pointers wrap naturally modulo DEPTH
  always_comb begin
    full_c      = (count_q == CNT_W'(DEPTH));
    empty_c     = (count_q == '0);
    push_acc_c  = push & ~full_c & ~flush;
    pop_acc_c   = pop & ~empty_c & ~flush;
    wr_nxt_c    = wr_ptr_q + PTR_W'(1);
    rd_nxt_c    = rd_ptr_q + PTR_W'(1);
    head_c      = mem_q[rd_ptr_q];
    next_head_c = mem_q[rd_nxt_c];
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc_c) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_nxt_c;
      end
      if (pop_acc_c) rd_ptr_d = rd_nxt_c;
      count_d = count_q + CNT_W'(push_acc_c) - CNT_W'(pop_acc_c);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/soc_system_vga_data_seq.sv
// Avalon-MM programmable byte sequencer feeding a valid/ready VGA data consumer,
// with optional idle gap between beats and drained/overflow interrupt.
module soc_system_vga_data_seq
  import soc_system_vga_data_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned GAP_RST = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [BUS_W-1:0]  writedata,
  output logic [BUS_W-1:0]  readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              irq
);

  seq_state_e        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [7:0]        gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic              enable_q, enable_d, irq_en_q, irq_en_d;
  logic              drained_q, drained_d, overflow_q, overflow_d;
  logic              irq_q, irq_d;

  logic              wr_c, push_c, flush_c, hs_c;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full_c, fifo_empty_c, fifo_push_acc_c, fifo_pop_acc_c;
  logic [DATA_W-1:0] fifo_head_c, fifo_next_head_c;
  logic              unused_wdata_c;

  assign unused_wdata_c = &{1'b0, writedata[BUS_W-1:8]};

  soc_system_vga_data_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (push_c),
    .pop         (hs_c),
    .flush       (flush_c),
    .din         (writedata[DATA_W-1:0]),
    .count       (fifo_count),
    .full_c      (fifo_full_c),
    .empty_c     (fifo_empty_c),
    .head_c      (fifo_head_c),
    .next_head_c (fifo_next_head_c),
    .push_acc_c  (fifo_push_acc_c),
    .pop_acc_c   (fifo_pop_acc_c)
  );

  always_comb begin
    wr_c    = chipselect & ~write_n;
    push_c  = wr_c & (address == ADDR_DATA);
    flush_c = wr_c & (address == ADDR_CTRL) & writedata[CTRL_FLUSH_BIT];
    hs_c    = (state_q == ST_PRESENT) & out_valid_q & out_ready;

    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    enable_d    = enable_q;
    irq_en_d    = irq_en_q;
    drained_d   = drained_q;
    overflow_d  = overflow_q;

    if (wr_c && address == ADDR_CTRL) begin
      enable_d = writedata[CTRL_ENABLE_BIT];
      irq_en_d = writedata[CTRL_IRQ_EN_BIT];
    end
    if (wr_c && address == ADDR_GAP) gap_d = writedata[7:0];
    if (wr_c && address == ADDR_STATUS) begin
      if (writedata[STS_DRAINED_BIT])  drained_d  = 1'b0;
      if (writedata[STS_OVERFLOW_BIT]) overflow_d = 1'b0;
    end
    // Hardware set events take priority over a same-cycle software clear
    if (fifo_pop_acc_c && fifo_count == CNT_W'(1) && !fifo_push_acc_c) drained_d = 1'b1;
    if (push_c && fifo_full_c && !flush_c) overflow_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (enable_q && fifo_count != '0) begin
          state_d     = ST_PRESENT;
          out_valid_d = 1'b1;
          out_data_d  = fifo_head_c;
        end
      end
      ST_PRESENT: begin
        if (hs_c) begin
          if (gap_q != '0) begin
            state_d     = ST_GAP;
            out_valid_d = 1'b0;
            gap_cnt_d   = gap_q;
          end else if (enable_q && fifo_count > CNT_W'(1)) begin
            out_data_d = fifo_next_head_c;
          end else begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
          end
        end
      end
      ST_GAP: begin
        // The final gap cycle resolves IDLE's decision so the idle run is exactly GAP cycles
        if (gap_cnt_q <= 8'd1) begin
          gap_cnt_d = '0;
          if (enable_q && fifo_count != '0) begin
            state_d     = ST_PRESENT;
            out_valid_d = 1'b1;
            out_data_d  = fifo_head_c;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    if (flush_c) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      gap_cnt_d   = '0;
    end

    irq_d = irq_en_d & (drained_d | overflow_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      gap_q       <= 8'(GAP_RST);
      gap_cnt_q   <= '0;
      enable_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      drained_q   <= 1'b0;
      overflow_q  <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      enable_q    <= enable_d;
      irq_en_q    <= irq_en_d;
      drained_q   <= drained_d;
      overflow_q  <= overflow_d;
      irq_q       <= irq_d;
    end
  end

  // Register read mux
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata = fifo_empty_c ? '0 : BUS_W'(fifo_head_c);
      ADDR_STATUS: readdata = BUS_W'({state_q, overflow_q, drained_q, fifo_count});
      ADDR_CTRL:   readdata = BUS_W'({irq_en_q, 1'b0, enable_q});
      ADDR_GAP:    readdata = BUS_W'(gap_q);
      default:     readdata = '0;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign irq       = irq_q;

endmodule
